vcve2_vmem_fsm: RTL and testbench
=================================

VCVE2_VMEM_FSM -- requirements
Module: vcve2_vmem_fsm

Interface
REQ-001 SHALL have parameter NumWords, 4, max 32-bit words per vector memory op (>=1).
REQ-002 SHALL have parameter MaxOutstanding, 2, max granted-but-unanswered requests (>=1).
REQ-003 SHALL have port clk_i  in  1  clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  in  1  op start; accepted only in IDLE.
REQ-006 SHALL have port is_store_i  in  1  1=store (VRF->mem), 0=load (mem->VRF).
REQ-007 SHALL have port base_addr_i  in  32  byte address of word 0.
REQ-008 SHALL have port stride_i  in  32  byte stride between words.
REQ-009 SHALL have port len_i  in  $clog2(NumWords+1)  words to transfer.
REQ-010 SHALL have port vrf_ridx_o  out  $clog2(NumWords)  VRF word index read for store data.
REQ-011 SHALL have port vrf_rdata_i  in  32  combinational VRF read data at vrf_ridx_o.
REQ-012 SHALL have ports vrf_we_o  out  1; vrf_widx_o  out  $clog2(NumWords); vrf_wdata_o  out  32: load write-back.
REQ-013 SHALL have ports data_req_o out 1, data_gnt_i in 1, data_rvalid_i in 1, data_we_o out 1, data_be_o out 4, data_addr_o out 32, data_wdata_o out 32, data_rdata_i in 32, data_err_i in 1: OBI-style port feeding one vrf_data_* slot of the dmem switch.
REQ-014 SHALL have ports busy_o  out  1; done_o  out  1 (one-cycle pulse); err_o  out  1 (sticky).

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE + start_i: latch is_store_i, len_i, base_addr_i, stride_i; clear err_o, counters; len_i==0 -> DONE, else -> ISSUE.
REQ-017 start_i outside IDLE SHALL be ignored.
REQ-018 ISSUE: data_req_o=1 iff issued<len and outstanding<MaxOutstanding and no error seen.
REQ-019 data_addr_o SHALL equal base+issued*stride, accumulated by adding stride per grant, modulo 2^32.
REQ-020 data_be_o SHALL be 4'hF; data_we_o=latched is_store; data_wdata_o=vrf_rdata_i with vrf_ridx_o=issued.
REQ-021 Request outputs SHALL remain stable while data_req_o=1 and data_gnt_i=0.
REQ-022 data_req_o & data_gnt_i: issued+1, outstanding+1; data_rvalid_i: outstanding-1, resp+1; both same cycle: outstanding unchanged.
REQ-023 Load rvalid SHALL assert vrf_we_o same cycle, vrf_widx_o=resp, vrf_wdata_o=data_rdata_i; store rvalid SHALL NOT write VRF.
REQ-024 data_rvalid_i & data_err_i SHALL set err_o, suppress that VRF write, and block further requests.
REQ-025 ISSUE -> DRAIN when issued==len (after grant) or error seen.
REQ-026 DRAIN -> DONE when outstanding is 0 after this cycle's rvalid.
REQ-027 DONE: done_o=1 exactly one cycle, -> IDLE next cycle.
REQ-028 data_rvalid_i in IDLE/DONE SHALL be ignored.
REQ-029 busy_o=1 in ISSUE, DRAIN, DONE.

Reset
REQ-030 rst_ni low SHALL asynchronously force IDLE, all counters 0, data_req_o=0, vrf_we_o=0, busy_o=0, done_o=0, err_o=0, data_addr_o=0.
REQ-031 Reset mid-op SHALL abandon outstanding transactions; responses after reset ignored.

Configuration
REQ-032 Macro VCVE2_VMEM_STRIDE_EN defined: stride_i used per REQ-019.
REQ-033 Macro undefined: stride fixed 32'd4 (unit-stride), stride_i ignored.

Verification
REQ-034 Load len=4 base=0x1000 stride=4, gnt=1, rvalid 1 cycle after gnt -> addrs 0x1000..0x100C, 4 VRF writes idx 0..3, done_o 1 cycle, err_o=0.
REQ-035 Store len=3 stride=0x10 (STRIDE_EN), gnt withheld 2 cycles on word 1 -> addr/wdata stable until grant, addrs 0x1000,0x1010,0x1020, no vrf_we_o.
REQ-036 MaxOutstanding=2, rvalid delayed 3 cycles -> data_req_o drops after 2 grants, resumes on first rvalid.
REQ-037 Load len=4, data_err_i on word 1 rvalid -> no VRF write idx 1, no new requests, drain, done_o with err_o=1.
REQ-038 base=0xFFFFFFF8 stride=4 len=3 -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; len=0 -> done_o next cycle, no data_req_o.
REQ-039 rst_ni low during DRAIN with 1 outstanding -> IDLE, outputs 0; later rvalid ignored.

Source files
------------

// File: rtl/vcve2_vmem_fsm.sv
// Vector memory load/store sequencer driving one OBI-style data port.
// Define VCVE2_VMEM_STRIDE_EN to honour stride_i; otherwise accesses are unit-stride (4 bytes).
module vcve2_vmem_fsm #(
   parameter int unsigned NumWords       = 4,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            start_i,
   input  logic                            is_store_i,
   input  logic [31:0]                     base_addr_i,
   input  logic [31:0]                     stride_i,
   input  logic [$clog2(NumWords+1)-1:0]   len_i,
   output logic [$clog2(NumWords)-1:0]     vrf_ridx_o,
   input  logic [31:0]                     vrf_rdata_i,
   output logic                            vrf_we_o,
   output logic [$clog2(NumWords)-1:0]     vrf_widx_o,
   output logic [31:0]                     vrf_wdata_o,
   output logic                            data_req_o,
   input  logic                            data_gnt_i,
   input  logic                            data_rvalid_i,
   output logic                            data_we_o,
   output logic [3:0]                      data_be_o,
   output logic [31:0]                     data_addr_o,
   output logic [31:0]                     data_wdata_o,
   input  logic [31:0]                     data_rdata_i,
   input  logic                            data_err_i,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            err_o
);

   localparam int unsigned LenW = $clog2(NumWords + 1);
   localparam int unsigned IdxW = $clog2(NumWords);
   localparam int unsigned OutW = $clog2(MaxOutstanding + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e            state_q, state_d;
   logic              store_q;
   logic [LenW-1:0]   len_q, issued_q, resp_q, issued_d;
   logic [OutW-1:0]   outst_q, outst_d;
   logic [31:0]       addr_q, stride_q;
   logic              err_q;
   logic              gnt_ok, rsp_ok, rsp_err;

`ifdef VCVE2_VMEM_STRIDE_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stride_q <= '0;
      end else if (state_q == IDLE && start_i) begin
         stride_q <= stride_i;
      end
   end
`else
   logic unused_stride;
   assign stride_q      = 32'd4;
   assign unused_stride = ^stride_i;
`endif

   always_comb begin
      state_d    = state_q;
      data_req_o = 1'b0;
      busy_o     = (state_q != IDLE);
      done_o     = (state_q == DONE);
      rsp_ok     = ((state_q == ISSUE) || (state_q == DRAIN)) && data_rvalid_i;
      rsp_err    = rsp_ok && data_err_i;
      vrf_we_o   = rsp_ok && !store_q && !data_err_i;

      if (state_q == ISSUE) begin
         data_req_o = (issued_q < len_q) && (outst_q < OutW'(MaxOutstanding)) && !err_q;
      end
      gnt_ok   = data_req_o && data_gnt_i;
      issued_d = issued_q + LenW'(gnt_ok);

      // A grant and a response in the same cycle leave the in-flight count unchanged.
      outst_d = outst_q;
      if (gnt_ok && !rsp_ok) begin
         outst_d = outst_q + OutW'(1);
      end else if (!gnt_ok && rsp_ok) begin
         outst_d = outst_q - OutW'(1);
      end

      unique case (state_q)
         IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : ISSUE;
         ISSUE:   if ((issued_d == len_q) || err_q || rsp_err) state_d = DRAIN;
         DRAIN:   if (outst_d == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         store_q  <= 1'b0;
         len_q    <= '0;
         issued_q <= '0;
         resp_q   <= '0;
         outst_q  <= '0;
         addr_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) begin
            if (start_i) begin
               store_q  <= is_store_i;
               len_q    <= len_i;
               addr_q   <= base_addr_i;
               issued_q <= '0;
               resp_q   <= '0;
               outst_q  <= '0;
               err_q    <= 1'b0;
            end
         end else begin
            issued_q <= issued_d;
            outst_q  <= outst_d;
            if (gnt_ok) addr_q <= addr_q + stride_q;
            if (rsp_ok) resp_q <= resp_q + LenW'(1);
            if (rsp_err) err_q <= 1'b1;
         end
      end
   end

   assign vrf_ridx_o   = issued_q[IdxW-1:0];
   assign vrf_widx_o   = resp_q[IdxW-1:0];
   assign vrf_wdata_o  = data_rdata_i;
   assign data_we_o    = store_q;
   assign data_be_o    = 4'hF;
   assign data_addr_o  = addr_q;
   assign data_wdata_o = vrf_rdata_i;
   assign err_o        = err_q;

endmodule

// File: tb/tb_vcve2_vmem_fsm.sv
// Self-checking bench for vcve2_vmem_fsm: directed and random ops against a transaction-level model.
module tb_vcve2_vmem_fsm;

   localparam int unsigned NW = 4;
   localparam int unsigned MO = 2;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        start_i, is_store_i;
   logic [31:0] base_addr_i, stride_i;
   logic [2:0]  len_i;
   logic [1:0]  vrf_ridx_o, vrf_widx_o;
   logic [31:0] vrf_rdata_i, vrf_wdata_o;
   logic        vrf_we_o;
   logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o, data_err_i;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
   logic        busy_o, done_o, err_o;

   logic [31:0] vrf_mem [NW];
   int          n_assert = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;
   assign vrf_rdata_i = vrf_mem[vrf_ridx_o];

   vcve2_vmem_fsm #(.NumWords(NW), .MaxOutstanding(MO)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .is_store_i(is_store_i),
      .base_addr_i(base_addr_i), .stride_i(stride_i), .len_i(len_i),
      .vrf_ridx_o(vrf_ridx_o), .vrf_rdata_i(vrf_rdata_i), .vrf_we_o(vrf_we_o),
      .vrf_widx_o(vrf_widx_o), .vrf_wdata_o(vrf_wdata_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
      .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One whole operation; the model tracks granted words, responses and errors only.
   task automatic run_op(input logic st, input int len, input logic [31:0] base,
                         input logic [31:0] stride, input int gnt_pct, input int lat_min,
                         input int lat_max, input int err_idx, input int hold_word,
                         input int hold_cycles);
      logic [31:0] eff;
      int          issued, resp, q[$], hold_left, due;
      bit          errs, finished, exp_req, rv, exp_vwe;
`ifdef VCVE2_VMEM_STRIDE_EN
      eff = stride;
`else
      eff = 32'd4;
`endif
      issued = 0; resp = 0; errs = 0; finished = 0; hold_left = hold_cycles;
      q.delete();
      for (int i = 0; i < int'(NW); i++) vrf_mem[i] = $urandom;

      @(negedge clk);
      start_i = 1'b1; is_store_i = st; len_i = 3'(len); base_addr_i = base; stride_i = stride;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      #1;
      chk("idle_busy", {31'd0, busy_o}, 32'd0);
      chk("idle_req", {31'd0, data_req_o}, 32'd0);
      chk("idle_done", {31'd0, done_o}, 32'd0);

      for (int cyc = 1; cyc < 200 && !finished; cyc++) begin
         @(negedge clk);
         start_i = ($urandom_range(0, 3) == 0);
         is_store_i = $urandom; len_i = $urandom; base_addr_i = $urandom; stride_i = $urandom;
         exp_req = (issued < len) && ((issued - resp) < int'(MO)) && !errs;
         rv = (q.size() > 0) && (q[0] <= cyc);
         data_rvalid_i = rv;
         data_rdata_i  = $urandom;
         data_err_i    = rv ? (resp == err_idx) : 1'($urandom);
         if (exp_req && issued == hold_word && hold_left > 0) begin
            data_gnt_i = 1'b0;
            hold_left--;
         end else begin
            data_gnt_i = ($urandom_range(0, 99) < gnt_pct);
         end
         #1;
         chk("busy", {31'd0, busy_o}, 32'd1);
         chk("req", {31'd0, data_req_o}, {31'd0, exp_req});
         if (exp_req) begin
            chk("addr", data_addr_o, base + 32'(issued) * eff);
            chk("wdata", data_wdata_o, vrf_mem[issued]);
            chk("we", {31'd0, data_we_o}, {31'd0, st});
            chk("be", {28'd0, data_be_o}, 32'hF);
         end
         exp_vwe = rv && !st && !data_err_i;
         chk("vrf_we", {31'd0, vrf_we_o}, {31'd0, exp_vwe});
         if (exp_vwe) begin
            chk("vrf_widx", {30'd0, vrf_widx_o}, 32'(resp));
            chk("vrf_wdata", vrf_wdata_o, data_rdata_i);
         end
         if (cyc == 1) chk("err_cleared", {31'd0, err_o}, 32'd0);
         if (len == 0 && cyc == 1) chk("len0_done", {31'd0, done_o}, 32'd1);
         if (done_o) begin
            chk("done_outst", 32'(issued - resp), 32'd0);
            chk("done_err", {31'd0, err_o}, {31'd0, errs});
            chk("done_complete", {31'd0, (errs || issued == len)}, 32'd1);
            finished = 1;
         end
         if (exp_req && data_gnt_i) begin
            issued++;
            due = cyc + $urandom_range(lat_min, lat_max);
            if (q.size() > 0 && q[$] > due) due = q[$];
            q.push_back(due);
         end
         if (rv) begin
            void'(q.pop_front());
            resp++;
            if (data_err_i) errs = 1;
         end
      end
      chk("timeout", {31'd0, finished}, 32'd1);
   endtask

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; is_store_i = 1'b0; base_addr_i = '0; stride_i = '0;
      len_i = '0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = '0;
      for (int i = 0; i < int'(NW); i++) vrf_mem[i] = '0;
      #12;
      chk("rst_req", {31'd0, data_req_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_vwe", {31'd0, vrf_we_o}, 32'd0);
      chk("rst_addr", data_addr_o, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;

      run_op(1'b0, 4, 32'h1000, 32'h4, 100, 1, 1, -1, -1, 0);
      run_op(1'b1, 3, 32'h1000, 32'h10, 100, 1, 1, -1, 1, 2);
      run_op(1'b0, 4, 32'h2000, 32'h4, 100, 3, 3, -1, -1, 0);
      run_op(1'b0, 4, 32'h3000, 32'h4, 100, 1, 1, 1, -1, 0);
      run_op(1'b0, 3, 32'hFFFF_FFF8, 32'h4, 100, 1, 1, -1, -1, 0);
      run_op(1'b1, 0, 32'h5000, 32'h4, 100, 1, 1, -1, -1, 0);
      for (int n = 0; n < 40; n++) begin
         run_op(1'($urandom), $urandom_range(0, NW), $urandom, $urandom,
                $urandom_range(30, 100), 1, $urandom_range(1, 4),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, NW - 1) : -1,
                $urandom_range(0, NW - 1), $urandom_range(0, 3));
      end

      // Reset while one load response is still in flight.
      @(negedge clk);
      start_i = 1'b1; is_store_i = 1'b0; len_i = 3'd1; base_addr_i = 32'h4000;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      @(negedge clk);
      start_i = 1'b0; data_gnt_i = 1'b1;
      #1 chk("mid_req", {31'd0, data_req_o}, 32'd1);
      @(negedge clk);
      data_gnt_i = 1'b0;
      #1 chk("mid_busy", {31'd0, busy_o}, 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, data_req_o}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
      chk("mid_rst_done", {31'd0, done_o}, 32'd0);
      chk("mid_rst_addr", data_addr_o, 32'd0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      data_rvalid_i = 1'b1; data_rdata_i = $urandom;
      #1;
      chk("late_rvalid_vwe", {31'd0, vrf_we_o}, 32'd0);
      chk("late_rvalid_busy", {31'd0, busy_o}, 32'd0);
      @(negedge clk);
      data_rvalid_i = 1'b0;
      #1 chk("late_rvalid_idle", {31'd0, busy_o}, 32'd0);
      run_op(1'b0, 2, 32'h6000, 32'h8, 100, 1, 2, -1, -1, 0);

      start_i = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
